// File: rtl/skeeball_pkg.sv
// skeeball_pkg: shared state encodings, default hole points and score ceiling
package skeeball_pkg;
    typedef enum logic [1:0] {
        ST_MENU   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FINISH = 2'b10,
        ST_LAST   = 2'b11
    } state_t;
    localparam logic [7:0] PTS_H0_DEF = 8'd1;
    localparam logic [7:0] PTS_H1_DEF = 8'd2;
    localparam logic [7:0] PTS_H2_DEF = 8'd3;
    localparam logic [7:0] PTS_H3_DEF = 8'd5;
    localparam logic [7:0] PTS_H4_DEF = 8'd10;
    localparam logic [7:0] SCORE_MAX  = 8'd255;
endpackage

// File: rtl/skeeball_game_ctrl_if.sv
// skeeball_game_ctrl_if: sensor inputs and game status outputs of the controller
interface skeeball_game_ctrl_if;
    logic       start;
    logic [4:0] hole;
    logic       gutter;
    logic [1:0] state;
    logic [7:0] score;
    logic [3:0] balls_left;
    logic [7:0] last_score;
    logic [7:0] high_score;
    modport master (output start, hole, gutter, input state, score, balls_left, last_score, high_score);
    modport slave (input start, hole, gutter, output state, score, balls_left, last_score, high_score);
endinterface

// File: rtl/skeeball_edge.sv
// skeeball_edge: 2-flop synchronizer followed by a rising-edge one-cycle pulse
module skeeball_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] p
);
    logic [W-1:0] s1, s2, prev;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end
    assign p = s2 & ~prev;
endmodule

// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl: skeeball phase FSM, ball counter, saturating score and score history
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int          BALLS_PER_GAME = 9,
    parameter logic [23:0] FINISH_CYCLES  = 24'd10_000_000,
    parameter logic [27:0] LAST_CYCLES    = 28'd250_000_000,
    parameter logic [7:0]  PTS_H0         = PTS_H0_DEF,
    parameter logic [7:0]  PTS_H1         = PTS_H1_DEF,
    parameter logic [7:0]  PTS_H2         = PTS_H2_DEF,
    parameter logic [7:0]  PTS_H3         = PTS_H3_DEF,
    parameter logic [7:0]  PTS_H4         = PTS_H4_DEF
) (
    input logic                 clk,
    input logic                 reset,
    skeeball_game_ctrl_if.slave bus
);
    localparam logic [3:0]  BALLS    = 4'(BALLS_PER_GAME);
    localparam logic [27:0] FIN_END  = {4'd0, FINISH_CYCLES} - 28'd1;
    localparam logic [27:0] LAST_END = LAST_CYCLES - 28'd1;
    logic [6:0] p;
    logic       start_p, gutter_p, ev;
    logic [4:0] hole_p;
    logic [7:0] pts, sat;
    logic [8:0] sum;
    state_t      state_q, state_d;
    logic [7:0]  score_q, score_d, last_q, last_d, high_q, high_d;
    logic [3:0]  balls_q, balls_d;
    logic [27:0] timer_q, timer_d;
    skeeball_edge #(.W(7)) u_edge (
        .clk   (clk),
        .reset (reset),
        .d     ({bus.gutter, bus.hole, bus.start}),
        .p     (p)
    );
    assign start_p  = p[0];
    assign hole_p   = p[5:1];
    assign gutter_p = p[6];
    assign ev       = (|hole_p) | gutter_p;
    // highest hole wins; a gutter alone scores nothing
    assign pts = hole_p[4] ? PTS_H4 : hole_p[3] ? PTS_H3 : hole_p[2] ? PTS_H2 :
                 hole_p[1] ? PTS_H1 : hole_p[0] ? PTS_H0 : 8'd0;
    assign sum = {1'b0, score_q} + {1'b0, pts};
    assign sat = sum[8] ? SCORE_MAX : sum[7:0];
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        balls_d = balls_q;
        last_d  = last_q;
        high_d  = high_q;
        timer_d = timer_q;
        case (state_q)
            ST_MENU: if (start_p) begin
                state_d = ST_PLAY;
                score_d = '0;
                balls_d = BALLS;
            end
            ST_PLAY: if (ev) begin
                score_d = sat;
                balls_d = balls_q - 4'd1;
                if (balls_q == 4'd1) begin
                    state_d = ST_FINISH;
                    timer_d = '0;
                    last_d  = sat;
                    high_d  = (sat > high_q) ? sat : high_q;
                end
            end
            ST_FINISH: begin
                timer_d = (timer_q == FIN_END) ? 28'd0 : timer_q + 28'd1;
                state_d = (timer_q == FIN_END) ? ST_LAST : ST_FINISH;
            end
            ST_LAST: if (start_p) begin
                state_d = ST_PLAY;
                score_d = '0;
                balls_d = BALLS;
            end else begin
                timer_d = (timer_q == LAST_END) ? 28'd0 : timer_q + 28'd1;
                state_d = (timer_q == LAST_END) ? ST_MENU : ST_LAST;
            end
            default: state_d = ST_MENU;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MENU;
            score_q <= '0;
            balls_q <= BALLS;
            last_q  <= '0;
            high_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            balls_q <= balls_d;
            last_q  <= last_d;
            high_q  <= high_d;
            timer_q <= timer_d;
        end
    end
    assign bus.state      = state_q;
    assign bus.score      = score_q;
    assign bus.balls_left = balls_q;
    assign bus.last_score = last_q;
    assign bus.high_score = high_q;
endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb_skeeball_game_ctrl: directed self-checking bench for skeeball_game_ctrl
module tb_skeeball_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       gutter = 1'b0;
    logic [4:0] hole = 5'd0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    skeeball_game_ctrl_if b0 ();
    skeeball_game_ctrl_if b1 ();
    assign b0.start  = start;
    assign b0.hole   = hole;
    assign b0.gutter = gutter;
    assign b1.start  = start;
    assign b1.hole   = hole;
    assign b1.gutter = gutter;
    skeeball_game_ctrl #(.FINISH_CYCLES(24'd20), .LAST_CYCLES(28'd30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );
    skeeball_game_ctrl #(.FINISH_CYCLES(24'd20), .LAST_CYCLES(28'd30), .PTS_H4(8'd50)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(input logic [4:0] h, input logic g, input logic s, input int hold);
        hole = h;
        gutter = g;
        start = s;
        tick(hold);
        hole = 5'd0;
        gutter = 1'b0;
        start = 1'b0;
        tick(3);
    endtask
    task automatic wait_state(input string tag, input int s, input int budget);
        for (int i = 0; i < budget && int'(b0.state) != s; i++) tick(1);
        check(tag, int'(b0.state), s);
    endtask
    task automatic gutters(input int n);
        for (int i = 0; i < n; i++) press(5'd0, 1'b1, 1'b0, 4);
    endtask
    initial begin
        tick(2);
        check("rst_state", b0.state, 0);
        check("rst_score", b0.score, 0);
        check("rst_balls", b0.balls_left, 9);
        check("rst_last", b0.last_score, 0);
        check("rst_high", b0.high_score, 0);
        reset = 1'b0;
        tick(1);
        press(5'b10000, 1'b0, 1'b0, 4);
        check("menu_hole_score", b0.score, 0);
        check("menu_hole_state", b0.state, 0);
        press(5'd0, 1'b0, 1'b1, 4);
        check("start_state", b0.state, 1);
        check("start_balls", b0.balls_left, 9);
        for (int i = 0; i < 9; i++) begin
            press(5'b10000, 1'b0, 1'b0, 4);
            tick(3);
            check("g1_score", b0.score, 10 * (i + 1));
            check("g1_balls", b0.balls_left, 8 - i);
            check("sat_score", b1.score, (50 * (i + 1) > 255) ? 255 : 50 * (i + 1));
        end
        check("g1_finish", b0.state, 2);
        check("g1_last", b0.last_score, 90);
        check("g1_high", b0.high_score, 90);
        check("sat_last", b1.last_score, 255);
        tick(11);
        check("finish_hold", b0.state, 2);
        tick(2);
        check("finish_to_last", b0.state, 3);
        press(5'b00001, 1'b1, 1'b0, 4);
        check("last_hole_score", b0.score, 90);
        check("last_hole_state", b0.state, 3);
        tick(22);
        check("last_hold", b0.state, 3);
        tick(1);
        check("last_to_menu", b0.state, 0);
        check("menu_keeps_last", b0.last_score, 90);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("rst2_high", b0.high_score, 0);
        tick(1);
        press(5'd0, 1'b0, 1'b1, 4);
        press(5'b10011, 1'b1, 1'b0, 4);
        check("simul_score", b0.score, 10);
        check("simul_balls", b0.balls_left, 8);
        press(5'b10000, 1'b0, 1'b0, 100);
        check("held_score", b0.score, 20);
        check("held_balls", b0.balls_left, 7);
        gutters(7);
        check("ga_state", b0.state, 2);
        check("ga_score", b0.score, 20);
        check("ga_balls", b0.balls_left, 0);
        check("ga_last", b0.last_score, 20);
        check("ga_high", b0.high_score, 20);
        wait_state("ga_wait_last", 3, 40);
        wait_state("ga_wait_menu", 0, 40);
        press(5'd0, 1'b0, 1'b1, 4);
        press(5'b10000, 1'b0, 1'b0, 4);
        press(5'b01000, 1'b0, 1'b0, 4);
        check("gb_score", b0.score, 15);
        gutters(7);
        check("gb_last", b0.last_score, 15);
        check("gb_high", b0.high_score, 20);
        wait_state("gb_wait_last", 3, 40);
        press(5'd0, 1'b0, 1'b1, 4);
        check("restart_state", b0.state, 1);
        check("restart_score", b0.score, 0);
        check("restart_balls", b0.balls_left, 9);
        press(5'b10000, 1'b0, 1'b0, 4);
        press(5'b10000, 1'b0, 1'b0, 4);
        gutters(7);
        check("gc_last", b0.last_score, 20);
        check("gc_high", b0.high_score, 20);
        wait_state("gc_wait_last", 3, 40);
        press(5'd0, 1'b0, 1'b1, 4);
        press(5'b10000, 1'b0, 1'b0, 4);
        press(5'b00010, 1'b0, 1'b0, 4);
        gutters(2);
        check("gd_score", b0.score, 12);
        check("gd_balls", b0.balls_left, 5);
        check("gd_state", b0.state, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_state", b0.state, 0);
        check("midrst_score", b0.score, 0);
        check("midrst_balls", b0.balls_left, 9);
        check("midrst_high", b0.high_score, 0);
        check("midrst_last", b0.last_score, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
